// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch stage. Owns the PC, issues word requests to
//            instruction memory over a req/ready handshake and presents the
//            fetched instruction to the IF/ID pipeline register. Absorbs ID
//            back-pressure through a one-entry hold buffer and handles delayed
//            branch and exception redirects.
// Options  : IF_ADDR_ERR_EN - when defined, a misaligned PC raises IF_AdEL
//            instead of fetching; when undefined, redirect targets are
//            word-aligned and IF_AdEL is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          HOLD_DEPTH   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ID_Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Exc_Req,
    input  logic [31:0] Exc_Vector,
    output logic        IMem_Req,
    output logic [29:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_RData,
    output logic [31:0] Instruction,
    output logic [31:0] PCAdd4,
    output logic [31:0] PCOut,
    output logic        IF_IsBDS,
    output logic        IF_Stall,
    output logic        IF_AdEL
);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_ERR   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [29:0] drain_addr_q, drain_addr_d;

    logic [31:0] w_exc_tgt;
    logic [31:0] w_br_tgt;
    logic        w_misalign;
    logic        w_adel;
    logic        w_fetch_ok;
    logic        w_valid;
    logic        w_consume;
    logic        w_br_new;
    logic        w_pend;
    logic [31:0] w_pend_tgt;
    logic [31:0] w_pc_add4;

`ifdef IF_ADDR_ERR_EN
    assign w_exc_tgt  = Exc_Vector;
    assign w_br_tgt   = BranchTarget;
    assign w_misalign = (pc_q[1:0] != 2'b00);
`else
    // Without address-error support the PC can never become misaligned.
    assign w_exc_tgt  = {Exc_Vector[31:2], 2'b00};
    assign w_br_tgt   = {BranchTarget[31:2], 2'b00};
    assign w_misalign = 1'b0;
    logic w_unused_bits;
    assign w_unused_bits = ^{Exc_Vector[1:0], BranchTarget[1:0]};
`endif

    // Only a single hold entry is implemented; the parameter documents that.
    logic w_unused_cfg;
    assign w_unused_cfg = (HOLD_DEPTH != 1);

    assign w_pc_add4  = pc_q + 32'd4;
    // A new branch is only recorded when none is pending and no exception wins.
    assign w_br_new   = BranchTaken & ~ID_Stall & ~Exc_Req & ~pend_valid_q;
    assign w_pend     = pend_valid_q | w_br_new;
    assign w_pend_tgt = pend_valid_q ? pend_tgt_q : w_br_tgt;
    assign w_fetch_ok = (state_q == c_ST_RUN) & IMem_Req & IMem_Ready;
    assign w_valid    = ~Exc_Req & (hold_valid_q | w_fetch_ok | w_adel);
    assign w_consume  = w_valid & ~ID_Stall;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= c_ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_BOOT:  state_d = c_ST_RUN;
            c_ST_RUN: begin
                if (Exc_Req) begin
                    // An unanswered request must be drained before refetching.
                    if (IMem_Req && !IMem_Ready) begin
                        state_d = c_ST_DRAIN;
                    end
                end else if (w_adel && !ID_Stall) begin
                    state_d = c_ST_ERR;
                end
            end
            c_ST_DRAIN: if (IMem_Ready) state_d = c_ST_RUN;
            c_ST_ERR:   if (Exc_Req) state_d = c_ST_RUN;
            default:    state_d = c_ST_BOOT;
        endcase
    end

    // FSM outputs: memory request, address and address-error slot
    always_comb begin
        IMem_Req  = 1'b0;
        IMem_Addr = pc_q[31:2];
        w_adel    = 1'b0;
        case (state_q)
            c_ST_RUN: begin
                if (w_misalign) begin
                    w_adel = 1'b1;
                end else begin
                    IMem_Req = ~hold_valid_q;
                end
            end
            c_ST_DRAIN: begin
                IMem_Req  = 1'b1;
                IMem_Addr = drain_addr_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: PC, hold buffer, pending branch, drain address
    always_comb begin
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        pend_valid_d = w_pend;
        pend_tgt_d   = w_pend_tgt;
        drain_addr_d = drain_addr_q;
        if (Exc_Req) begin
            pc_d         = w_exc_tgt;
            hold_valid_d = 1'b0;
            pend_valid_d = 1'b0;
            if (state_q == c_ST_RUN) begin
                drain_addr_d = pc_q[31:2];
            end
        end else if (w_consume) begin
            pc_d         = w_pend ? w_pend_tgt : w_pc_add4;
            hold_valid_d = 1'b0;
            pend_valid_d = 1'b0;
        end else if (w_valid && !hold_valid_q && !w_adel) begin
            hold_valid_d = 1'b1;
            hold_instr_d = IMem_RData;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q         <= RESET_VECTOR;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= 32'd0;
            drain_addr_q <= 30'd0;
        end else begin
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign PCOut       = pc_q;
    assign PCAdd4      = w_pc_add4;
    assign IF_Stall    = ~w_valid;
    assign IF_IsBDS    = w_valid & w_pend;
    assign IF_AdEL     = w_valid & w_adel;
    assign Instruction = (w_valid && !w_adel) ? (hold_valid_q ? hold_instr_q : IMem_RData)
                                              : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit with a latency-configurable
//            memory model and a scoreboard of expected consumed instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bds;
    } sb_entry_t;

    logic        CLK;
    logic        RST;
    logic        ID_Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Exc_Req;
    logic [31:0] Exc_Vector;
    logic        IMem_Req;
    logic [29:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_RData;
    logic [31:0] Instruction;
    logic [31:0] PCAdd4;
    logic [31:0] PCOut;
    logic        IF_IsBDS;
    logic        IF_Stall;
    logic        IF_AdEL;

    if_fetch_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .ID_Stall     (ID_Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Exc_Req      (Exc_Req),
        .Exc_Vector   (Exc_Vector),
        .IMem_Req     (IMem_Req),
        .IMem_Addr    (IMem_Addr),
        .IMem_Ready   (IMem_Ready),
        .IMem_RData   (IMem_RData),
        .Instruction  (Instruction),
        .PCAdd4       (PCAdd4),
        .PCOut        (PCOut),
        .IF_IsBDS     (IF_IsBDS),
        .IF_Stall     (IF_Stall),
        .IF_AdEL      (IF_AdEL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 0;
    int          wait_cnt = 0;
    sb_entry_t   sb_q[$];

    // Staged stimulus, applied on the falling edge
    logic        st_rst = 1'b1;
    logic        st_id_stall = 1'b0;
    logic        st_br = 1'b0;
    logic [31:0] st_tgt = 32'd0;
    logic        st_exc = 1'b0;
    logic [31:0] st_vec = 32'd0;

    // Outputs captured mid-cycle
    logic        s_req, s_stall, s_bds, s_adel;
    logic [29:0] s_addr;
    logic [31:0] s_pc, s_instr;

    function automatic logic [31:0] memw(input logic [29:0] a);
        return {a[27:0], 4'hC} ^ 32'h5A5A_0F0F ^ {2'b00, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic push_norm(input logic [31:0] pc, input logic bds);
        sb_entry_t e;
        e.pc    = pc;
        e.instr = memw(pc[31:2]);
        e.bds   = bds;
        sb_q.push_back(e);
    endtask

    task automatic push_raw(input logic [31:0] pc, input logic [31:0] instr, input logic bds);
        sb_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.bds   = bds;
        sb_q.push_back(e);
    endtask

    task automatic step();
        sb_entry_t e;
        @(negedge CLK);
        RST          = st_rst;
        ID_Stall     = st_id_stall;
        BranchTaken  = st_br;
        BranchTarget = st_tgt;
        Exc_Req      = st_exc;
        Exc_Vector   = st_vec;
        IMem_Ready   = IMem_Req && (wait_cnt >= mem_lat);
        IMem_RData   = IMem_Ready ? memw(IMem_Addr) : 32'hDEAD_BEEF;
        #1;
        s_req   = IMem_Req;
        s_addr  = IMem_Addr;
        s_stall = IF_Stall;
        s_bds   = IF_IsBDS;
        s_adel  = IF_AdEL;
        s_pc    = PCOut;
        s_instr = Instruction;
        if (!IF_Stall && !ID_Stall) begin
            check_eq("sb_avail", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("pcout", PCOut, e.pc);
                check_eq("instr", Instruction, e.instr);
                check_eq("pcadd4", PCAdd4, e.pc + 32'd4);
                check_eq("isbds", IF_IsBDS, e.bds);
            end
        end
        @(posedge CLK);
        wait_cnt = (s_req && !IMem_Ready) ? wait_cnt + 1 : 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RST = 1'b1; ID_Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0;
        Exc_Req = 1'b0; Exc_Vector = 32'd0; IMem_Ready = 1'b0; IMem_RData = 32'd0;

        // Reset state
        run(2);
        check_eq("rst_req", s_req, 0);
        check_eq("rst_stall", s_stall, 1);
        check_eq("rst_instr", s_instr, 0);
        check_eq("rst_bds", s_bds, 0);
        check_eq("rst_adel", s_adel, 0);
        check_eq("rst_pc", s_pc, 32'hBFC0_0000);

        // BOOT cycle, then zero-wait streaming
        st_rst = 1'b0;
        step();
        check_eq("boot_req", s_req, 0);
        for (int i = 0; i < 4; i++) push_norm(32'hBFC0_0000 + 32'(4 * i), 1'b0);
        step();
        check_eq("first_addr", s_addr, 30'h2FF0_0000);
        check_eq("first_req", s_req, 1);
        run(3);
        check_eq("stream_done", sb_q.size(), 0);

        // Memory answering after 3 cycles
        mem_lat = 3;
        push_norm(32'hBFC0_0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("lat_stall", s_stall, 1);
            check_eq("lat_addr", s_addr, 30'h2FF0_0004);
        end
        step();
        check_eq("lat_done", sb_q.size(), 0);
        mem_lat = 0;

        // Exception to 0x100, then ID back-pressure for 4 cycles
        st_exc = 1'b1; st_vec = 32'h0000_0100;
        step();
        check_eq("exc_nop", s_stall, 1);
        st_exc = 1'b0;
        push_norm(32'h0000_0100, 1'b0);
        st_id_stall = 1'b1;
        step();
        check_eq("hold_first_stall", s_stall, 0);
        check_eq("hold_first_pc", s_pc, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_no_req", s_req, 0);
            check_eq("hold_pc", s_pc, 32'h0000_0100);
            check_eq("hold_instr", s_instr, memw(30'h40));
        end
        st_id_stall = 1'b0;
        step();
        check_eq("hold_done", sb_q.size(), 0);

        // Delayed branch with the delay slot present in IF
        push_norm(32'h0000_0104, 1'b1);
        st_br = 1'b1; st_tgt = 32'h0000_2000;
        step();
        st_br = 1'b0;
        push_norm(32'h0000_2000, 1'b0);
        push_norm(32'h0000_2004, 1'b0);
        run(2);

        // Branch before the delay slot arrives; a second branch is ignored
        mem_lat = 2;
        push_norm(32'h0000_2008, 1'b1);
        st_br = 1'b1; st_tgt = 32'h0000_3000;
        step();
        st_tgt = 32'h0000_4000;
        step();
        st_br = 1'b0;
        step();
        mem_lat = 0;
        push_norm(32'h0000_3000, 1'b0);
        step();
        check_eq("branch_done", sb_q.size(), 0);

        // Exception with an outstanding request: drain and discard
        mem_lat = 3;
        st_exc = 1'b1; st_vec = 32'h8000_0180;
        step();
        check_eq("drain_exc_stall", s_stall, 1);
        st_exc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("drain_stall", s_stall, 1);
            check_eq("drain_addr", s_addr, 30'h0000_0C01);
        end
        mem_lat = 0;
        push_norm(32'h8000_0180, 1'b0);
        push_norm(32'h8000_0184, 1'b0);
        run(2);

        // Exception and branch together: the vector wins, nothing pending
        st_exc = 1'b1; st_vec = 32'h0000_0500;
        st_br = 1'b1; st_tgt = 32'h0000_0600;
        step();
        check_eq("excbr_stall", s_stall, 1);
        check_eq("excbr_bds", s_bds, 0);
        st_exc = 1'b0; st_br = 1'b0;
        push_norm(32'h0000_0500, 1'b0);
        push_norm(32'h0000_0504, 1'b0);
        run(2);

        // PC wrap at the top of the address space
        st_exc = 1'b1; st_vec = 32'hFFFF_FFFC;
        step();
        st_exc = 1'b0;
        push_norm(32'hFFFF_FFFC, 1'b0);
        push_norm(32'h0000_0000, 1'b0);
        step();
        step();
        check_eq("wrap_addr", s_addr, 30'h0);

        // Misaligned redirect target
        st_exc = 1'b1; st_vec = 32'h0000_1002;
        step();
        st_exc = 1'b0;
`ifdef IF_ADDR_ERR_EN
        push_raw(32'h0000_1002, 32'd0, 1'b0);
        step();
        check_eq("adel_flag", s_adel, 1);
        check_eq("adel_req", s_req, 0);
        step();
        check_eq("adel_wait_stall", s_stall, 1);
        check_eq("adel_wait_req", s_req, 0);
        st_exc = 1'b1; st_vec = 32'h0000_0700;
        step();
        st_exc = 1'b0;
        push_norm(32'h0000_0700, 1'b0);
        step();
`else
        push_raw(32'h0000_1000, memw(30'h400), 1'b0);
        step();
        check_eq("align_adel", s_adel, 0);
`endif
        check_eq("sb_final", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
